// File: rtl/pc_ctrl_pkg.sv
// Shared PC-source select encodings and front-end PC sequencer state type.
// Pure declarations; no logic, no latency.
package pc_ctrl_pkg;

  localparam logic [1:0] PC_4      = 2'b00;
  localparam logic [1:0] PC_IMM    = 2'b01;
  localparam logic [1:0] PC_IMMRS1 = 2'b10;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_sel.sv
// Redirect target mux with JALR bit-0 clear, misalign detect and word-alignment force.
// Purely combinational (0 cycles); no handshake, never backpressures.
module pc_target_sel
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      branch_ctrl,
  input  logic [XLEN-1:0] pc_imm,
  input  logic [XLEN-1:0] pc_immrs1,
  output logic            is_redirect_sel,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    raw_target      = '0;
    is_redirect_sel = 1'b0;
    case (branch_ctrl)
      PC_IMM: begin
        raw_target      = pc_imm;
        is_redirect_sel = 1'b1;
      end
      PC_IMMRS1: begin
        raw_target      = {pc_immrs1[XLEN-1:1], 1'b0};
        is_redirect_sel = 1'b1;
      end
      default: begin
        raw_target      = '0;
        is_redirect_sel = 1'b0;
      end
    endcase
  end

  // A misaligned target is still taken, just forced onto a word boundary.
  assign misalign = |raw_target[1:0];
  assign target   = {raw_target[XLEN-1:2], 2'b00};

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC register, fetch request and IF/ID, ID/EX stall/flush control; redirect reaches pc 1 cycle after the fetch is accepted.
// Fetch held while imem_ready=0; optional perf counters under PC_REDIRECT_PERF_EN.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      branch_ctrl,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] pc_imm,
  input  logic [XLEN-1:0] pc_immrs1,
  input  logic            load_use,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] pc,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_flush,
`ifdef PC_REDIRECT_PERF_EN
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_stall_cycles,
`endif
  output logic            target_misalign
);

  pc_state_e       state;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] target;
  logic            is_redirect_sel;
  logic            misalign;
  logic            redirect;
  logic            active;

  pc_target_sel #(
    .XLEN(XLEN)
  ) u_target_sel (
    .branch_ctrl    (branch_ctrl),
    .pc_imm         (pc_imm),
    .pc_immrs1      (pc_immrs1),
    .is_redirect_sel(is_redirect_sel),
    .target         (target),
    .misalign       (misalign)
  );

  assign redirect = ex_valid && is_redirect_sel;
  assign active   = !rst && (state == RUN || state == PEND);

  always_comb begin
    imem_req        = 1'b0;
    if_id_stall     = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    target_misalign = 1'b0;
    if (active) begin
      imem_req        = 1'b1;
      target_misalign = redirect && misalign;
      if (state == RUN) begin
        // Redirect squashes the younger instructions, so it overrides the load-use hold.
        if (redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end else begin
        // The word returning for the old pc is wrong-path and must not enter IF/ID.
        if_id_flush = redirect || imem_ready;
        id_ex_flush = redirect;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_target <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect) begin
            if (imem_ready) begin
              pc <= target;
            end else begin
              pend_target <= target;
              state       <= PEND;
            end
          end else if (!load_use && imem_ready) begin
            pc <= pc + XLEN'(4);
          end
        end
        PEND: begin
          if (redirect) begin
            pend_target <= target;
          end
          // The newest redirect wins if it lands in the same cycle the stalled fetch completes.
          if (imem_ready) begin
            pc    <= redirect ? target : pend_target;
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef PC_REDIRECT_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (active && redirect && perf_redirects != '1) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
      if (if_id_stall && perf_stall_cycles != '1) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed vector table for the front-end PC sequencer followed by random traffic against a reference model.
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  branch_ctrl;
  logic        ex_valid;
  logic [31:0] pc_imm;
  logic [31:0] pc_immrs1;
  logic        load_use;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] pc;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        target_misalign;
`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stall_cycles;
`endif

  pc_redirect_ctrl #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_ctrl    (branch_ctrl),
    .ex_valid       (ex_valid),
    .pc_imm         (pc_imm),
    .pc_immrs1      (pc_immrs1),
    .load_use       (load_use),
    .imem_ready     (imem_ready),
    .imem_req       (imem_req),
    .pc             (pc),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
`ifdef PC_REDIRECT_PERF_EN
    .perf_redirects   (perf_redirects),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .target_misalign(target_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  bc;
    logic        exv;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        lu;
    logic        rdy;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_stall;
    logic        e_idf;
    logic        e_exf;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: "booting" is the single idle cycle after reset,
  // pend_q holds at most one redirect target waiting for the old fetch to finish.
  bit          m_booting;
  logic [31:0] m_pc;
  logic [31:0] pend_q[$];

  logic [31:0] x_pc;
  logic        x_req, x_stall, x_idf, x_exf, x_mis;

  task automatic drive(input logic r, input logic [1:0] bc, input logic exv, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic lu, input logic rdy);
    rst = r; branch_ctrl = bc; ex_valid = exv; pc_imm = imm; pc_immrs1 = rs1;
    load_use = lu; imem_ready = rdy;
  endtask

  function automatic logic is_redir();
    return ex_valid && (branch_ctrl == 2'b01 || branch_ctrl == 2'b10);
  endfunction

  function automatic logic [31:0] raw_tgt();
    return (branch_ctrl == 2'b01) ? pc_imm : (pc_immrs1 & ~32'd1);
  endfunction

  task automatic model_expect();
    logic [31:0] t;
    x_pc = m_pc; x_req = 0; x_stall = 0; x_idf = 0; x_exf = 0; x_mis = 0;
    if (!rst && !m_booting) begin
      t     = raw_tgt();
      x_req = 1;
      x_mis = is_redir() && (t % 4 != 0);
      if (pend_q.size() == 0) begin
        x_stall = !is_redir() && load_use;
        x_idf   = is_redir();
        x_exf   = is_redir() || load_use;
      end else begin
        x_idf = is_redir() || imem_ready;
        x_exf = is_redir();
      end
    end
  endtask

  task automatic model_update();
    logic [31:0] t;
    t = raw_tgt() - (raw_tgt() % 4);
    if (rst) begin
      m_booting = 1; m_pc = 32'h0; pend_q.delete();
    end else if (m_booting) begin
      m_booting = 0;
    end else if (pend_q.size() == 0) begin
      if (is_redir()) begin
        if (imem_ready) m_pc = t;
        else pend_q.push_back(t);
      end else if (!load_use && imem_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (is_redir()) pend_q[0] = t;
      if (imem_ready) m_pc = pend_q.pop_front();
    end
  endtask

  task automatic compare(input string name, input int idx, input logic [31:0] e_pc, input logic e_req,
                         input logic e_stall, input logic e_idf, input logic e_exf, input logic e_mis);
    checks++;
    if (pc !== e_pc || imem_req !== e_req || if_id_stall !== e_stall || if_id_flush !== e_idf ||
        id_ex_flush !== e_exf || target_misalign !== e_mis) begin
      failures++;
      $display("FAIL %s[%0d] got pc=%h req=%b stall=%b iff=%b exf=%b mis=%b want pc=%h req=%b stall=%b iff=%b exf=%b mis=%b",
               name, idx, pc, imem_req, if_id_stall, if_id_flush, id_ex_flush, target_misalign,
               e_pc, e_req, e_stall, e_idf, e_exf, e_mis);
    end
  endtask

  initial begin
    // rst bc exv imm rs1 lu rdy | pc req stall iff exf mis
    tbl.push_back('{1, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0});   // BOOT
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h4, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h8, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'hC, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 32'h80, 0, 0, 1, 32'h10, 1, 0, 1, 1, 0}); // taken branch
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h80, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 2, 1, 0, 32'h103, 0, 0, 32'h84, 1, 0, 1, 1, 1}); // JALR misaligned, mem wait
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 32'h84, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 32'h84, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 32'h84, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h84, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 1, 32'h20, 0, 0, 1, 32'h100, 1, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 32'h20, 1, 1, 0, 1, 0});  // load-use
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h20, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 32'h40, 0, 1, 1, 32'h24, 1, 0, 1, 1, 0}); // redirect beats load-use
    tbl.push_back('{0, 3, 1, 32'h998, 0, 1, 1, 32'h40, 1, 1, 0, 1, 0}); // 11 is sequential
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 1, 32'h200, 0, 0, 0, 32'h44, 1, 0, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0, 0, 0});  // reset while pending
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 32'h500, 0, 0, 1, 32'h4, 1, 0, 0, 0, 0}); // ex_valid=0 ignored
    tbl.push_back('{0, 1, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h8, 1, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0});   // wrapped
    tbl.push_back('{0, 1, 1, 32'h300, 0, 0, 0, 32'h4, 1, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 32'h4, 1, 0, 0, 0, 0});   // load-use ignored in PEND
    tbl.push_back('{0, 2, 1, 0, 32'h401, 0, 0, 32'h4, 1, 0, 1, 1, 0}); // overwrite pending target
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h4, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 32'h400, 1, 0, 0, 0, 0});

    m_booting = 1; m_pc = 32'h0;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].bc, tbl[i].exv, tbl[i].imm, tbl[i].rs1, tbl[i].lu, tbl[i].rdy);
      #1;
      compare("vec", i, tbl[i].e_pc, tbl[i].e_req, tbl[i].e_stall, tbl[i].e_idf, tbl[i].e_exf, tbl[i].e_mis);
      @(posedge clk);
      model_update();
      @(negedge clk);
    end

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(63) == 0), 2'($urandom_range(3)), 1'($urandom_range(1)),
            $urandom() & 32'h0000_FFFF, $urandom() & 32'h0000_FFFF,
            ($urandom_range(4) == 0), ($urandom_range(9) < 7));
      #1;
      model_expect();
      compare("rand", n, x_pc, x_req, x_stall, x_idf, x_exf, x_mis);
      @(posedge clk);
      model_update();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
